// File: rtl/coproc_regs_pkg.sv
// Register map, field positions and master FSM state codes shared by the
// coprocessor register slave and the command master.
package coproc_regs_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ALG_W  = 2;
  localparam int unsigned ZOOM_W = 3;
  localparam int unsigned POLL_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_START  = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd2;

  localparam int unsigned ALG_LSB   = 0;
  localparam int unsigned ZOOM_LSB  = 2;
  localparam int unsigned START_BIT = 0;
  localparam int unsigned DONE_BIT  = 0;

  localparam logic [DATA_W-1:0] START_WORD = DATA_W'(1) << START_BIT;

  // Command master states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_CTRL   = 3'd1;
  localparam logic [2:0] ST_GAP_CTRL  = 3'd2;
  localparam logic [2:0] ST_WR_START  = 3'd3;
  localparam logic [2:0] ST_GAP_START = 3'd4;
  localparam logic [2:0] ST_POLL_RD   = 3'd5;
  localparam logic [2:0] ST_POLL_WAIT = 3'd6;
  localparam logic [2:0] ST_RESP      = 3'd7;

  typedef struct packed {
    logic [ZOOM_W-1:0] zoom;
    logic [ALG_W-1:0]  algorithm;
  } job_t;

  function automatic logic [DATA_W-1:0] ctrl_word(input job_t j);
    logic [DATA_W-1:0] w;
    w = '0;
    w[ALG_LSB +: ALG_W]   = j.algorithm;
    w[ZOOM_LSB +: ZOOM_W] = j.zoom;
    return w;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired_c is high once the count has reached zero.
module cycle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/coproc_cmd_master.sv
// Bus master that programs the coprocessor register slave for one job:
// CTRL write, START write, then STATUS polling until done or timeout.
module coproc_cmd_master
  import coproc_regs_pkg::*;
#(
  parameter int unsigned WRITE_HOLD     = 2,
  parameter int unsigned WRITE_GAP      = 2,
  parameter int unsigned POLL_INTERVAL  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ALG_W-1:0]  cmd_algorithm,
  input  logic [ZOOM_W-1:0] cmd_zoom,
  output logic              rsp_valid,
  output logic              rsp_timeout,
  output logic [POLL_W-1:0] rsp_polls,
  output logic              busy,
  output logic [ADDR_W-1:0] bus_address,
  output logic              bus_chipselect,
  output logic              bus_write,
  output logic              bus_read,
  output logic [DATA_W-1:0] bus_writedata,
  input  logic [DATA_W-1:0] bus_readdata
);

  localparam int unsigned HG_MAX  = (WRITE_HOLD > WRITE_GAP) ? WRITE_HOLD : WRITE_GAP;
  localparam int unsigned TMR_MAX = (HG_MAX > POLL_INTERVAL) ? HG_MAX : POLL_INTERVAL;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(WRITE_HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(WRITE_GAP - 1);
  localparam logic [TMR_W-1:0] INT_LAST  = TMR_W'(POLL_INTERVAL - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]        state, state_next;
  job_t              job, job_next;
  logic [POLL_W-1:0] poll_cnt, poll_cnt_next;
  logic [TO_W-1:0]   to_cnt, to_cnt_next;
  logic              timeout_next;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_value;
  logic              tmr_expired_c;
  logic              done_c;
  logic              to_fire_c;
  logic              cs_next, wr_next, rd_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] data_next;
  logic              readdata_unused_c;

  assign done_c            = bus_readdata[DONE_BIT];
  assign readdata_unused_c = ^bus_readdata;
  // Timeout fires at the end of the TIMEOUT_CYCLES-th cycle of the poll phase
  assign to_fire_c = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

  cycle_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expired_c  (tmr_expired_c)
  );

  // Next-state, counters and next bus beat
  always_comb begin
    state_next    = state;
    job_next      = job;
    poll_cnt_next = poll_cnt;
    to_cnt_next   = to_cnt;
    timeout_next  = 1'b0;
    tmr_load      = 1'b0;
    tmr_value     = '0;
    cs_next       = 1'b0;
    wr_next       = 1'b0;
    rd_next       = 1'b0;
    addr_next     = '0;
    data_next     = '0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next    = ST_WR_CTRL;
          job_next      = '{zoom: cmd_zoom, algorithm: cmd_algorithm};
          poll_cnt_next = '0;
          tmr_load      = 1'b1;
          tmr_value     = HOLD_LAST;
        end
      end
      ST_WR_CTRL: begin
        if (tmr_expired_c) begin
          state_next = ST_GAP_CTRL;
          tmr_load   = 1'b1;
          tmr_value  = GAP_LAST;
        end
      end
      ST_GAP_CTRL: begin
        if (tmr_expired_c) begin
          state_next = ST_WR_START;
          tmr_load   = 1'b1;
          tmr_value  = HOLD_LAST;
        end
      end
      ST_WR_START: begin
        if (tmr_expired_c) begin
          state_next = ST_GAP_START;
          tmr_load   = 1'b1;
          tmr_value  = GAP_LAST;
        end
      end
      ST_GAP_START: begin
        if (tmr_expired_c) begin
          state_next  = ST_POLL_RD;
          to_cnt_next = '0;
        end
      end
      ST_POLL_RD: begin
        to_cnt_next = to_cnt + TO_W'(1);
        if (poll_cnt != '1) begin
          poll_cnt_next = poll_cnt + POLL_W'(1);
        end
        if (done_c) begin
          state_next = ST_RESP;
        end else if (to_fire_c) begin
          state_next   = ST_RESP;
          timeout_next = 1'b1;
        end else begin
          state_next = ST_POLL_WAIT;
          tmr_load   = 1'b1;
          tmr_value  = INT_LAST;
        end
      end
      ST_POLL_WAIT: begin
        to_cnt_next = to_cnt + TO_W'(1);
        if (to_fire_c) begin
          state_next   = ST_RESP;
          timeout_next = 1'b1;
        end else if (tmr_expired_c) begin
          state_next = ST_POLL_RD;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    case (state_next)
      ST_WR_CTRL: begin
        cs_next   = 1'b1;
        wr_next   = 1'b1;
        addr_next = ADDR_CTRL;
        data_next = ctrl_word(job_next);
      end
      ST_WR_START: begin
        cs_next   = 1'b1;
        wr_next   = 1'b1;
        addr_next = ADDR_START;
        data_next = START_WORD;
      end
      ST_POLL_RD: begin
        cs_next   = 1'b1;
        rd_next   = 1'b1;
        addr_next = ADDR_STATUS;
      end
      default: begin
        cs_next = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      job            <= '0;
      poll_cnt       <= '0;
      to_cnt         <= '0;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_timeout    <= 1'b0;
      rsp_polls      <= '0;
      bus_address    <= '0;
      bus_chipselect <= 1'b0;
      bus_write      <= 1'b0;
      bus_read       <= 1'b0;
      bus_writedata  <= '0;
    end else begin
      state          <= state_next;
      job            <= job_next;
      poll_cnt       <= poll_cnt_next;
      to_cnt         <= to_cnt_next;
      cmd_ready      <= (state_next == ST_IDLE);
      busy           <= (state_next != ST_IDLE);
      rsp_valid      <= (state_next == ST_RESP);
      rsp_timeout    <= (state_next == ST_RESP) && timeout_next;
      rsp_polls      <= (state_next == ST_RESP) ? poll_cnt_next : '0;
      bus_address    <= addr_next;
      bus_chipselect <= cs_next;
      bus_write      <= wr_next;
      bus_read       <= rd_next;
      bus_writedata  <= data_next;
    end
  end

endmodule

// File: doc/coproc_cmd_master.md
# coproc_cmd_master

Bus-initiator counterpart to the coprocessor register slave. It accepts a job request (algorithm, zoom) over a valid/ready handshake and drives the slave's 2-bit-address register bus. It writes the control register, then the start register, then polls the status register until `processing_done` reads 1 or a timeout expires, and reports the outcome. It sits in the FPGA fabric on `clk`, replacing the HPS as bus master for self-test and standalone (button/UART-driven) operation.

## Interface
- `WRITE_HOLD`, 2: cycles `write`/`chipselect`/`address`/`writedata` are held per write beat; legal range ≥1.
- `WRITE_GAP`, 2: idle cycles after each write beat, so the slave's edge detector re-arms; legal range ≥2.
- `POLL_INTERVAL`, 8: idle cycles between status reads; legal range ≥1.
- `TIMEOUT_CYCLES`, 1_000_000: cycles allowed in the poll phase; 0 disables the timeout.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: job request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_algorithm` in 2: algorithm select, captured on accept.
- `cmd_zoom` in 3: zoom level, captured on accept.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_timeout` out 1: valid with `rsp_valid`; 1 means a timeout occurred.
- `rsp_polls` out 16: number of status reads issued, valid with `rsp_valid`, saturates at 16'hFFFF.
- `busy` out 1: high in every state except IDLE.
- `bus_address` out 2, `bus_chipselect` out 1, `bus_write` out 1, `bus_read` out 1, `bus_writedata` out 32: master side of the register bus.
- `bus_readdata` in 32: combinational read return from the slave (zero read latency).

## Operation
- Address map constants: CTRL=0, START=1, STATUS=2.
- CTRL writedata is `{27'b0, zoom[2:0], algorithm[1:0]}`. START writedata is 32'h1.
- States and transitions:
  - IDLE → WR_CTRL on `cmd_valid && cmd_ready`; algorithm and zoom are latched.
  - WR_CTRL (WRITE_HOLD cycles) → GAP_CTRL (WRITE_GAP cycles) → WR_START (WRITE_HOLD) → GAP_START (WRITE_GAP) → POLL_RD.
  - POLL_RD lasts 1 cycle: `chipselect=1`, `read=1`, `address=2`. `bus_readdata[0]` is sampled at the closing edge and the poll counter increments.
    - Bit 1 → RESP.
    - Bit 0 → POLL_WAIT for POLL_INTERVAL cycles, then POLL_RD.
  - Timeout counter starts at entry to the first POLL_RD. If it reaches TIMEOUT_CYCLES (nonzero) before done is seen → RESP with `rsp_timeout=1`. A read that sees done on the same edge the timeout fires wins (`rsp_timeout=0`).
  - RESP lasts 1 cycle: `rsp_valid=1` → IDLE.
- Bus outputs (`address`, `writedata`, `chipselect`, `write`, `read`) are all 0 in IDLE, GAP_*, POLL_WAIT, and RESP. `write` and `read` are never high together.
- `cmd_valid` while busy is ignored (`cmd_ready=0`). There is no queueing.
- Reset, including mid-operation, asynchronously returns to IDLE. All outputs go to 0 except `cmd_ready=1`, and counters clear. A write beat cut short by reset is not retried.

## Timing
- Accept at edge 0. WR_CTRL occupies cycles 1..WRITE_HOLD.
- The first START beat begins at cycle 1+WRITE_HOLD+WRITE_GAP.
- The first POLL_RD is at cycle 1+2·(WRITE_HOLD+WRITE_GAP); with defaults, cycle 9.
- Poll period is 1+POLL_INTERVAL cycles (9 with defaults).
- `rsp_valid` rises the cycle after the deciding POLL_RD. `cmd_ready` returns the cycle after RESP.
- Registered outputs only. No combinational path from `bus_readdata` to any output.

## Structure
- Shared package `coproc_regs_pkg` holds:
  - address constants CTRL/START/STATUS;
  - field positions ALG_LSB=0, ZOOM_LSB=2, START_BIT=0, DONE_BIT=0;
  - the state enum.
  The register slave imports the same constants.
- One generic down-counter sub-module, `cycle_timer`, is reused for the hold, gap, and interval phases. The timeout and poll counters are inline.

## Test plan
- Job alg=2, zoom=3, defaults; bench slave with done asserted 40 cycles after start → CTRL write 32'h0000000E at cycles 1–2, START write 32'h1 at cycles 5–6. Read at cycle 9, then every 9 cycles. `rsp_valid` with `rsp_timeout=0`, `rsp_polls=5`.
- Done already high at first poll → `rsp_polls=1`, `rsp_valid` at cycle 10.
- TIMEOUT_CYCLES=50, done never asserted → `rsp_timeout=1`, `rsp_polls=6`. Bus idle afterwards.
- `cmd_valid` held continuously → second job accepted exactly 1 cycle after RESP. Pulses during busy produce no bus activity.
- Reset asserted during WR_START → `bus_write=0` immediately, `cmd_ready=1`. The next job runs a full sequence from CTRL.
- Integrated with the real register slave: zoom=5, alg=1 → slave outputs update and emit exactly one start pulse per job.
